// File: rtl/pattern_serializer_pkg.sv
// Shared types and constants for the pattern serializer.
package pattern_serializer_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        IDLE,
        PRE,
        SHIFT,
        GAP
    } state_t;

    // Frame preamble, sent left to right when PATTERN_SERIALIZER_PREAMBLE_EN is defined
    localparam int              PRE_LEN  = 4;
    localparam logic [PRE_LEN-1:0] PREAMBLE = 4'b1010;

endpackage

// File: rtl/pattern_serializer.sv
// Programmable serial pattern transmitter.
// Accepts a 1..WIDTH bit pattern over valid/ready and shifts it out MSB-first
// on seq, one bit per clock, optionally followed by GAP_CYCLES idle cycles.
// Optional feature: define PATTERN_SERIALIZER_PREAMBLE_EN to prefix every frame
// with the 4-bit PREAMBLE from the package.
module pattern_serializer
    import pattern_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int LEN_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             seq,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int              GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] ONE_GAP  = GAP_W'(1);

    state_t           state;
    logic [WIDTH-1:0] shreg;      // data bits not yet placed on seq, left-aligned
    logic [LEN_W-1:0] bits_left;  // number of valid bits remaining in shreg
    logic [GAP_W-1:0] gap_cnt;    // gap cycles remaining, including the current one
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
    logic [1:0]       pre_idx;    // index of the preamble bit currently on seq
`endif

    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;
    logic             last_bit;
    logic             take;

    // Normalise the requested length and left-align the pattern so its first bit sits at the MSB
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        eff_len = pat_len;
        if ((pat_len == '0) || (pat_len > FULL_LEN)) begin
            eff_len = FULL_LEN;
        end
        aligned = pat_data << (FULL_LEN - eff_len);
    end

    // Handshake and status decode from the registered state
    always_comb begin
        last_bit  = (state == SHIFT) && (bits_left == '0);
        pat_ready = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
        take      = pat_valid && pat_ready;
        busy      = seq_valid || (state == GAP);
    end

    // FSM, shift register, counters and registered serial outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
            gap_cnt   <= '0;
            seq       <= 1'b0;
            seq_valid <= 1'b0;
            done      <= 1'b0;
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
            pre_idx   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            done <= 1'b0;
            if (take) begin
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
                state     <= PRE;
                seq       <= PREAMBLE[PRE_LEN-1];
                seq_valid <= 1'b1;
                pre_idx   <= 2'(PRE_LEN - 1);
                shreg     <= aligned;
                bits_left <= eff_len;
`else
                state     <= SHIFT;
                seq       <= aligned[WIDTH-1];
                seq_valid <= 1'b1;
                shreg     <= {aligned[WIDTH-2:0], 1'b0};
                bits_left <= eff_len - ONE_LEN;
                done      <= (eff_len == ONE_LEN);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        seq       <= 1'b0;
                        seq_valid <= 1'b0;
                    end
                    PRE: begin
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
                        if (pre_idx == 2'd0) begin
                            // Preamble finished: first data bit follows with no hole
                            state     <= SHIFT;
                            seq       <= shreg[WIDTH-1];
                            shreg     <= {shreg[WIDTH-2:0], 1'b0};
                            bits_left <= bits_left - ONE_LEN;
                            done      <= (bits_left == ONE_LEN);
                        end else begin
                            seq     <= PREAMBLE[pre_idx - 2'd1];
                            pre_idx <= pre_idx - 2'd1;
                        end
`else
                        // Unreachable without the preamble; recover to idle
                        state     <= IDLE;
                        seq       <= 1'b0;
                        seq_valid <= 1'b0;
`endif
                    end
                    SHIFT: begin
                        if (bits_left != '0) begin
                            seq       <= shreg[WIDTH-1];
                            shreg     <= {shreg[WIDTH-2:0], 1'b0};
                            bits_left <= bits_left - ONE_LEN;
                            done      <= (bits_left == ONE_LEN);
                        end else if (GAP_CYCLES > 0) begin
                            state     <= GAP;
                            gap_cnt   <= GAP_LOAD;
                            seq       <= 1'b0;
                            seq_valid <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            seq       <= 1'b0;
                            seq_valid <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == ONE_GAP) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - ONE_GAP;
                        end
                    end
                endcase
            end
        end
    end

endmodule
